mux8_rr_arbiter: RTL and testbench



---
 rtl/mux8_rr_arbiter_if.sv | 22 ++
 rtl/mux8_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mux8_rr_arbiter_if.sv
// Bus between the eight requesters and the round-robin arbiter that owns
// the shared 8:1 mux select.
interface mux8_rr_arbiter_if;
  logic [7:0] req;        // one request per requester, bit i = mux input i
  logic       done;       // current owner has finished
  logic [2:0] s;          // mux select, index of current/last owner
  logic [7:0] gnt;        // one-hot grant, zero when idle
  logic       gnt_valid;  // a grant is active
  logic       timeout;    // one-cycle pulse after a forced release

  // Requester side: drives requests, observes the grant.
  modport master (
    output req, done,
    input  s, gnt, gnt_valid, timeout
  );

  // Arbiter side.
  modport slave (
    input  req, done,
    output s, gnt, gnt_valid, timeout
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for the shared 8:1 mux. Grants one requester at a
// time, drives the mux select with the owner index, and releases on done,
// request drop or hold limit. All outputs come straight from flops.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,  // 0 disables the hold limit
  parameter int unsigned CNT_W    = 5    // 2**CNT_W must exceed MAX_HOLD
) (
  input  logic              clk,
  input  logic              rst_n,
  mux8_rr_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // Counter value seen on the last cycle of a full-length grant.
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [2:0]       s_q, s_d;
  logic [7:0]       gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ptr_q, ptr_d;

  logic [2:0]       win;
  logic             found;
  logic [2:0]       cand;
  logic             owner_req;
  logic             at_limit;

  // Rotating priority scan: first set request starting at ptr, wrapping mod 8.
  // Scanning from the far end lets the nearest hit overwrite later ones.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise an unassigned path infers a latch.
    win   = ptr_q;
    found = 1'b0;
    cand  = '0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr_q + 3'(i);
      if (bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Release qualifiers for the current owner.
  always_comb begin
    owner_req = bus.req[s_q];
    at_limit  = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    unique case (state_q)
      IDLE: begin
        // s keeps the last owner so the mux output stays put while idle.
        if (found) begin
          s_d     = win;
          gnt_d   = 8'b1 << win;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        if (bus.done || !owner_req || at_limit) begin
          gnt_d     = '0;
          valid_d   = 1'b0;
          ptr_d     = s_q + 3'd1;
          state_d   = IDLE;
          // Only a pure timeout pulses; done or a drop on the same edge wins.
          timeout_d = at_limit && !bus.done && owner_req;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_q       <= '0;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      s_q       <= s_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with MAX_HOLD=16. Inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_mux8_rr_arbiter;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  mux8_rr_arbiter_if bus ();

  mux8_rr_arbiter #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] g, input logic [2:0] s,
                           input logic v, input logic t);
    check({tag, ".gnt"},       32'(bus.gnt),       32'(g));
    check({tag, ".s"},         32'(bus.s),         32'(s));
    check({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(v));
    check({tag, ".timeout"},   32'(bus.timeout),   32'(t));
  endtask

  initial begin
    logic [2:0] order [4];
    vectors     = 0;
    miscompares = 0;
    order       = '{3'd2, 3'd5, 3'd2, 3'd5};

    // 1. Reset, then idle with no requests.
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    #12 rst_n = 1'b1;
    check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("idle_no_req", 8'h00, 3'd0, 1'b0, 1'b0);
    end

    // 2. Requesters 2 and 5 alternate, done three cycles into each grant.
    bus.req = 8'h24;
    tick();
    check_out("rr_first", 8'h04, 3'd2, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 2; c++) begin
        tick();
        check_out("rr_hold", 8'h1 << order[k], order[k], 1'b1, 1'b0);
      end
      bus.done = 1'b1;
      tick();
      check_out("rr_bubble", 8'h00, order[k], 1'b0, 1'b0);
      bus.done = 1'b0;
      if (k == 3) bus.req = 8'h00;
      tick();
      if (k < 3) check_out("rr_next", 8'h1 << order[k+1], order[k+1], 1'b1, 1'b0);
      else       check_out("rr_idle", 8'h00, 3'd5, 1'b0, 1'b0);
    end

    // 3. Requester 7 holds to the limit: 16 grant cycles, then timeout.
    bus.req = 8'h80;
    tick();
    check_out("hold7_grant", 8'h80, 3'd7, 1'b1, 1'b0);
    for (int c = 0; c < 15; c++) begin
      tick();
      check_out("hold7_held", 8'h80, 3'd7, 1'b1, 1'b0);
    end
    tick();
    check_out("hold7_timeout", 8'h00, 3'd7, 1'b0, 1'b1);
    tick();
    check_out("hold7_regrant", 8'h80, 3'd7, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick();
    check_out("hold7_done", 8'h00, 3'd7, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 8'h00;
    tick();
    check_out("hold7_idle", 8'h00, 3'd7, 1'b0, 1'b0);

    // 4. Owner 3 signals done on the limit edge: normal release, no pulse.
    bus.req = 8'h08;
    tick();
    check_out("lim3_grant", 8'h08, 3'd3, 1'b1, 1'b0);
    for (int c = 0; c < 15; c++) tick();
    check_out("lim3_last", 8'h08, 3'd3, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick();
    check_out("lim3_release", 8'h00, 3'd3, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 8'h00;
    tick();
    check_out("lim3_idle", 8'h00, 3'd3, 1'b0, 1'b0);

    // 5. Owner 4 drops its request; requester 0 wins next after the wrap.
    bus.req = 8'h10;
    tick();
    check_out("drop4_grant", 8'h10, 3'd4, 1'b1, 1'b0);
    tick();
    bus.req = 8'h01;
    tick();
    check_out("drop4_release", 8'h00, 3'd4, 1'b0, 1'b0);
    tick();
    check_out("drop4_next", 8'h01, 3'd0, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
    check_out("drop0_release", 8'h00, 3'd0, 1'b0, 1'b0);
    bus.done = 1'b1;
    tick();
    check_out("done_in_idle", 8'h00, 3'd0, 1'b0, 1'b0);
    bus.done = 1'b0;

    // 6. Asynchronous reset mid-grant of owner 6, then pointer restarts at 0.
    bus.req = 8'h40;
    tick();
    check_out("rst6_grant", 8'h40, 3'd6, 1'b1, 1'b0);
    bus.done = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_out("rst6_async", 8'h00, 3'd0, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 8'hFF;
    tick();
    check_out("rst6_held", 8'h00, 3'd0, 1'b0, 1'b0);
    #4 rst_n = 1'b1;
    tick();
    check_out("rst6_first", 8'h01, 3'd0, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick();
    check_out("ff_release0", 8'h00, 3'd0, 1'b0, 1'b0);
    bus.done = 1'b0;
    tick();
    check_out("ff_next1", 8'h02, 3'd1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
